mc_control: RTL and testbench

Multicycle control unit for the 32-bit CPU. It is the producer side of the ALU control interface: it decodes the latched instruction fields into `Aluc`, consumes the ALU's `Z` and `V` flags, and sequences fetch/decode/execute/memory/write-back one state per clock. It also drives every datapath enable and multiplexer select.

---
 rtl/cpu_ctrl_pkg.sv | 53 +++++
 rtl/alu_dec.sv | 49 ++++
 rtl/mc_control.sv | 168 ++++++++++++++++
 tb/tb_mc_control.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state codes, opcode/funct constants and ALU codes for the multicycle control unit
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_EXR = 4'd2,
    S_EXI = 4'd3,
    S_MA  = 4'd4,
    S_MR  = 4'd5,
    S_MW  = 4'd6,
    S_WBR = 4'd7,
    S_WBI = 4'd8,
    S_WBL = 4'd9,
    S_BR  = 4'd10,
    S_J   = 4'd11
  } state_t;

  // Selects which decode rule the ALU decoder applies in the current state.
  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_MEM,
    CLS_R,
    CLS_I,
    CLS_BR
  } alu_cls_t;

  localparam logic [1:0] ALUC_ADD = 2'b00;
  localparam logic [1:0] ALUC_SUB = 2'b01;
  localparam logic [1:0] ALUC_AND = 2'b10;
  localparam logic [1:0] ALUC_OR  = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  // Only the arithmetic operations can overflow; logical ones never suppress write-back.
  function automatic logic is_arith(input logic [5:0] op, input logic [5:0] func);
    return ((op == OP_RTYPE) && ((func == FN_ADD) || (func == FN_SUB))) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - maps state class, opcode and funct to ALU operation, extend mode and illegal flag
module alu_dec
  import cpu_ctrl_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [1:0] aluc,
  output logic       ext_op,
  output logic       illegal
);

  always_comb begin
    aluc   = ALUC_ADD;
    ext_op = 1'b0;
    case (cls)
      CLS_MEM: ext_op = 1'b1;
      CLS_BR:  aluc = ALUC_SUB;
      CLS_R: begin
        case (func)
          FN_SUB:  aluc = ALUC_SUB;
          FN_AND:  aluc = ALUC_AND;
          FN_OR:   aluc = ALUC_OR;
          default: aluc = ALUC_ADD;
        endcase
      end
      CLS_I: begin
        case (op)
          OP_ADDI: ext_op = 1'b1;
          OP_ANDI: aluc = ALUC_AND;
          OP_ORI:  aluc = ALUC_OR;
          default: aluc = ALUC_ADD;
        endcase
      end
      default: aluc = ALUC_ADD;
    endcase
  end

  always_comb begin
    illegal = 1'b1;
    case (op)
      OP_RTYPE: illegal = !((func == FN_ADD) || (func == FN_SUB) ||
                            (func == FN_AND) || (func == FN_OR));
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle CPU control FSM driving datapath enables, selects and ALU control
module mc_control
  import cpu_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       Clrn,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Z,
  input  logic       V,
  output logic [1:0] Aluc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] PCSource,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       Ovf,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t   state_q, state_d;
  logic     ovf_q, ovf_d;
  alu_cls_t cls;
  logic [1:0] dec_aluc;
  logic     dec_ext_op;
  logic     dec_illegal;

  always_comb begin
    cls = CLS_NONE;
    case (state_q)
      S_EXR:   cls = CLS_R;
      S_EXI:   cls = CLS_I;
      S_MA:    cls = CLS_MEM;
      S_BR:    cls = CLS_BR;
      default: cls = CLS_NONE;
    endcase
  end

  alu_dec u_alu_dec (
    .cls     (cls),
    .op      (Op),
    .func    (Func),
    .aluc    (dec_aluc),
    .ext_op  (dec_ext_op),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d = S_IF;
    ovf_d   = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (dec_illegal) begin
          state_d = S_IF;
        end else begin
          case (Op)
            OP_RTYPE:                 state_d = S_EXR;
            OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXI;
            OP_LW, OP_SW:             state_d = S_MA;
            OP_BEQ, OP_BNE:           state_d = S_BR;
            OP_J:                     state_d = S_J;
            default:                  state_d = S_IF;
          endcase
        end
      end
      S_EXR: begin
        state_d = S_WBR;
        ovf_d   = is_arith(Op, Func) & V;
      end
      S_EXI: begin
        state_d = S_WBI;
        ovf_d   = is_arith(Op, Func) & V;
      end
      S_MA:    state_d = (Op == OP_LW) ? S_MR : S_MW;
      S_MR:    state_d = S_WBL;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= S_IF;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Write enables and pulses are gated by Clrn so nothing commits while reset is held.
  always_comb begin
    Aluc     = dec_aluc;
    ExtOp    = dec_ext_op;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    PCSource = 2'b00;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    Ovf      = 1'b0;
    Illegal  = 1'b0;
    case (state_q)
      S_IF: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        Illegal = dec_illegal;
      end
      S_EXR: ALUSrcA = 1'b1;
      S_EXI, S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MR: IorD = 1'b1;
      S_MW: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_WBR: begin
        RegWrite = ~ovf_q;
        RegDst   = 1'b1;
        Ovf      = ovf_q;
      end
      S_WBI: begin
        RegWrite = ~ovf_q;
        Ovf      = ovf_q;
      end
      S_WBL: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_BR: begin
        ALUSrcA  = 1'b1;
        PCSource = 2'b01;
        PCWrite  = ((Op == OP_BEQ) & Z) | ((Op == OP_BNE) & ~Z);
      end
      S_J: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ALUSrcA = 1'b0;
    endcase
    IRWrite  = IRWrite  & Clrn;
    PCWrite  = PCWrite  & Clrn;
    MemWrite = MemWrite & Clrn;
    RegWrite = RegWrite & Clrn;
    Ovf      = Ovf      & Clrn;
    Illegal  = Illegal  & Clrn;
  end

  assign State = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed self-checking bench for mc_control
module tb_mc_control;

  logic       Clk;
  logic       Clrn;
  logic [5:0] Op;
  logic [5:0] Func;
  logic       Z;
  logic       V;
  logic [1:0] Aluc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] PCSource;
  logic       RegDst;
  logic       MemtoReg;
  logic       Ovf;
  logic       Illegal;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  mc_control dut (
    .Clk      (Clk),
    .Clrn     (Clrn),
    .Op       (Op),
    .Func     (Func),
    .Z        (Z),
    .V        (V),
    .Aluc     (Aluc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ExtOp    (ExtOp),
    .IorD     (IorD),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .MemWrite (MemWrite),
    .RegWrite (RegWrite),
    .PCSource (PCSource),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .Ovf      (Ovf),
    .Illegal  (Illegal),
    .State    (State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_state(input string tag, input logic [3:0] exp);
    @(negedge Clk);
    check(tag, {28'd0, State}, {28'd0, exp});
  endtask

  task automatic start(input logic [5:0] op, input logic [5:0] func);
    Op   = op;
    Func = func;
    check("start_if", {28'd0, State}, 32'd0);
    step_state("id", 4'd1);
  endtask

  task automatic branch(input string tag, input logic [5:0] op, input logic z, input logic exp_pcw);
    Z = z;
    start(op, 6'd0);
    step_state({tag, "_st"}, 4'd10);
    check({tag, "_pcw"}, {31'd0, PCWrite}, {31'd0, exp_pcw});
    check({tag, "_pcsrc"}, {30'd0, PCSource}, 32'd1);
    check({tag, "_aluc"}, {30'd0, Aluc}, 32'd1);
    Z = ~z;
    #1;
    check({tag, "_mealy"}, {31'd0, PCWrite}, {31'd0, ~exp_pcw});
    step_state({tag, "_ret"}, 4'd0);
  endtask

  initial begin
    Clrn = 1'b0;
    Op   = 6'b000000;
    Func = 6'b100000;
    Z    = 1'b0;
    V    = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_state", {28'd0, State}, 32'd0);
    check("rst_wen", {28'd0, IRWrite, PCWrite, MemWrite, RegWrite}, 32'd0);
    check("rst_pulse", {30'd0, Ovf, Illegal}, 32'd0);
    Clrn = 1'b1;
    #1;
    check("rel_fetch", {30'd0, IRWrite, PCWrite}, 32'b11);

    // add, no overflow
    step_state("add_id", 4'd1);
    step_state("add_exr", 4'd2);
    check("add_aluc", {30'd0, Aluc}, 32'd0);
    check("add_srca", {31'd0, ALUSrcA}, 32'd1);
    step_state("add_wbr", 4'd7);
    check("add_wb", {29'd0, RegWrite, RegDst, Ovf}, 32'b110);
    step_state("add_ret", 4'd0);

    // sub with overflow
    start(6'b000000, 6'b100010);
    step_state("sub_exr", 4'd2);
    check("sub_aluc", {30'd0, Aluc}, 32'd1);
    V = 1'b1;
    step_state("sub_wbr", 4'd7);
    V = 1'b0;
    check("sub_wb", {30'd0, RegWrite, Ovf}, 32'b01);
    check("sub_pcw", {31'd0, PCWrite}, 32'd0);
    step_state("sub_ret", 4'd0);
    check("sub_ovf_clr", {31'd0, Ovf}, 32'd0);

    // andi with V high must not flag overflow
    start(6'b001100, 6'd0);
    step_state("andi_exi", 4'd3);
    check("andi_ctl", {27'd0, Aluc, ExtOp, ALUSrcB}, {27'd0, 2'b10, 1'b0, 2'b10});
    V = 1'b1;
    step_state("andi_wbi", 4'd8);
    V = 1'b0;
    check("andi_wb", {29'd0, RegWrite, RegDst, Ovf}, 32'b100);
    step_state("andi_ret", 4'd0);

    // addi with overflow
    start(6'b001000, 6'd0);
    step_state("addi_exi", 4'd3);
    check("addi_ctl", {29'd0, Aluc, ExtOp}, 32'b001);
    V = 1'b1;
    step_state("addi_wbi", 4'd8);
    V = 1'b0;
    check("addi_wb", {30'd0, RegWrite, Ovf}, 32'b01);
    step_state("addi_ret", 4'd0);

    branch("beq_z1", 6'b000100, 1'b1, 1'b1);
    branch("beq_z0", 6'b000100, 1'b0, 1'b0);
    branch("bne_z1", 6'b000101, 1'b1, 1'b0);
    branch("bne_z0", 6'b000101, 1'b0, 1'b1);
    Z = 1'b0;

    // lw
    start(6'b100011, 6'd0);
    step_state("lw_ma", 4'd4);
    check("lw_ma_ctl", {28'd0, ExtOp, ALUSrcA, ALUSrcB}, 32'b1110);
    step_state("lw_mr", 4'd5);
    check("lw_iord", {31'd0, IorD}, 32'd1);
    step_state("lw_wbl", 4'd9);
    check("lw_wb", {30'd0, MemtoReg, RegWrite}, 32'b11);
    step_state("lw_ret", 4'd0);

    // sw
    start(6'b101011, 6'd0);
    check("sw_id_mw", {31'd0, MemWrite}, 32'd0);
    step_state("sw_ma", 4'd4);
    check("sw_ma_mw", {31'd0, MemWrite}, 32'd0);
    step_state("sw_mw", 4'd6);
    check("sw_mw_ctl", {30'd0, IorD, MemWrite}, 32'b11);
    step_state("sw_ret", 4'd0);
    check("sw_ret_mw", {31'd0, MemWrite}, 32'd0);

    // j
    start(6'b000010, 6'd0);
    step_state("j_st", 4'd11);
    check("j_ctl", {29'd0, PCWrite, PCSource}, 32'b110);
    step_state("j_ret", 4'd0);

    // illegal opcode and illegal funct
    start(6'b111111, 6'd0);
    check("ill_op", {30'd0, Illegal, Ovf}, 32'b10);
    step_state("ill_op_ret", 4'd0);
    check("ill_op_clr", {31'd0, Illegal}, 32'd0);
    start(6'b000000, 6'b000111);
    check("ill_fn", {31'd0, Illegal}, 32'd1);
    step_state("ill_fn_ret", 4'd0);

    // reset dropped during MW
    start(6'b101011, 6'd0);
    step_state("mrst_ma", 4'd4);
    step_state("mrst_mw", 4'd6);
    check("mrst_mw_pre", {31'd0, MemWrite}, 32'd1);
    Clrn = 1'b0;
    #1;
    check("mrst_mw_now", {31'd0, MemWrite}, 32'd0);
    check("mrst_state", {28'd0, State}, 32'd0);
    check("mrst_wen", {28'd0, IRWrite, PCWrite, MemWrite, RegWrite}, 32'd0);
    @(negedge Clk);
    check("mrst_hold", {28'd0, State}, 32'd0);
    Clrn = 1'b1;
    #1;
    check("mrst_rel", {30'd0, IRWrite, PCWrite}, 32'b11);
    step_state("mrst_id", 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
